pipeline_result_collector: RTL and testbench

// Downstream companion to a fixed-latency, non-stallable datapath pipeline (clk/rst/input_valid/x -> out).

---
 rtl/pipeline_result_collector.sv | 128 ++++++++++++
 tb/tb_pipeline_result_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_result_collector.sv
// ---------------------------------------------------------------------------
// pipeline_result_collector
//
// Sits downstream of a fixed-latency, non-stallable datapath pipeline.
// Operands are issued into the pipeline only when a FIFO slot is already
// reserved for the result, so the pipeline never needs to stall. Each issued
// transaction is tracked through a private valid shift register (the pipeline's
// own output valid is not used). When the tracker says a result has arrived,
// pipe_data is written into the result FIFO, which is drained over a
// ready/valid interface with full backpressure.
//
// Ports
//   clk          in   1                   clock, all state on posedge
//   rst          in   1                   asynchronous reset, active-high
//   issue_valid  in   1                   upstream has an operand to issue
//   issue_ready  out  1                   a result slot is reserved for a new issue
//   pipe_valid   out  1                   pipeline input_valid (= issue fire)
//   pipe_data    in   DATA_WIDTH          pipeline result, LATENCY cycles after issue
//   out_valid    out  1                   result FIFO non-empty
//   out_ready    in   1                   consumer accepts head of FIFO
//   out_data     out  DATA_WIDTH          FIFO head, 0 when empty
//   inflight     out  $clog2(LATENCY+1)   transactions currently inside the pipeline
// ---------------------------------------------------------------------------
module pipeline_result_collector #(
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 3,
   parameter int DEPTH      = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          issue_valid,
   output logic                          issue_ready,
   output logic                          pipe_valid,
   input  logic [DATA_WIDTH-1:0]         pipe_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [$clog2(LATENCY+1)-1:0]  inflight
);

   localparam int INF_W = $clog2(LATENCY + 1);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SUM_W = OCC_W + INF_W;

   logic [LATENCY-1:0]    vsr;
   logic [OCC_W-1:0]      occ;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  issue_fire;
   logic                  push;
   logic                  pop;
   logic [SUM_W-1:0]      credit_used;

   function automatic logic [INF_W-1:0] popcount(input logic [LATENCY-1:0] bits);
      logic [INF_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < LATENCY; i++) begin
         cnt = cnt + INF_W'(bits[i]);
      end
      return cnt;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      // Explicit wrap so non-power-of-two depths work.
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Credit check uses registered state only: every in-flight transaction
   // already owns a FIFO slot, so no combinational path from out_ready or
   // issue_valid reaches issue_ready.
   assign inflight    = popcount(vsr);
   assign credit_used = SUM_W'(occ) + SUM_W'(inflight);
   assign issue_ready = credit_used < SUM_W'(DEPTH);
   assign issue_fire  = issue_valid & issue_ready;
   assign pipe_valid  = issue_fire;

   assign push        = vsr[LATENCY-1];
   assign out_valid   = (occ != '0);
   assign pop         = out_valid & out_ready;
   assign out_data    = out_valid ? mem[rd_ptr] : '0;

   // ---- tracker stage: valid bit ages alongside the pipeline's data ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsr <= '0;
      end else begin
         vsr[0] <= issue_fire;
         for (int i = 1; i < LATENCY; i++) begin
            vsr[i] <= vsr[i-1];
         end
      end
   end

   // ---- FIFO control stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // ---- FIFO storage: data only, never reset ----
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= pipe_data;
      end
   end

   // The credit scheme guarantees a slot for every arriving result.
   push_into_full : assert property (@(posedge clk) disable iff (rst) !(push && (occ == OCC_W'(DEPTH))));

endmodule

// File: tb/tb_pipeline_result_collector.sv
module tb_pipeline_result_collector;

   logic        clk = 1'b0;
   logic        rst;

   // DUT A: DEPTH=5
   logic        issue_valid, issue_ready, pipe_valid, out_valid, out_ready;
   logic [31:0] pipe_data, out_data, x;
   logic [1:0]  inflight;

   // DUT B: DEPTH=2
   logic        b_issue_valid, b_issue_ready, b_pipe_valid, b_out_valid, b_out_ready;
   logic [31:0] b_pipe_data, b_out_data, b_x;
   logic [1:0]  b_inflight;

   int checks   = 0;
   int failures = 0;
   int pops_a   = 0;
   int pops_b   = 0;

   logic [31:0] q_a [$];
   logic [31:0] q_b [$];

   always #5 clk = ~clk;

   pipeline_result_collector #(.DATA_WIDTH(32), .LATENCY(3), .DEPTH(5)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .pipe_valid(pipe_valid), .pipe_data(pipe_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .inflight(inflight));

   pipeline_result_collector #(.DATA_WIDTH(32), .LATENCY(3), .DEPTH(2)) dut_b (
      .clk(clk), .rst(rst), .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
      .pipe_valid(b_pipe_valid), .pipe_data(b_pipe_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .inflight(b_inflight));

   // Pipeline model: result = x + 2, three register stages; junk when not valid.
   logic [31:0] a1, a2, a3, c1, c2, c3;
   always @(posedge clk) begin
      a1 <= pipe_valid ? x + 32'd2 : 32'hDEAD_BEEF;
      a2 <= a1;
      a3 <= a2;
      c1 <= b_pipe_valid ? b_x + 32'd2 : 32'hBAD0_BAD0;
      c2 <= c1;
      c3 <= c2;
   end
   assign pipe_data   = a3;
   assign b_pipe_data = c3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs are stable at negedge; events happen at the next posedge.
   always @(negedge clk) begin
      if (!rst) begin
         check("pipe_valid_a", pipe_valid, issue_valid & issue_ready);
         if (issue_valid && issue_ready) q_a.push_back(x + 32'd2);
         if (out_valid && out_ready) begin
            pops_a++;
            if (q_a.size() == 0) check("unexpected_out_a", out_data, 32'hFFFF_FFFF);
            else check("sb_data_a", out_data, q_a.pop_front());
         end
         if (b_issue_valid && b_issue_ready) q_b.push_back(b_x + 32'd2);
         if (b_out_valid && b_out_ready) begin
            pops_b++;
            if (q_b.size() == 0) check("unexpected_out_b", b_out_data, 32'hFFFF_FFFF);
            else check("sb_data_b", b_out_data, q_b.pop_front());
         end
      end
   end

   typedef struct {
      logic        iv;
      logic [31:0] xv;
      logic        ordy;
      logic        e_ov;
      logic [31:0] e_od;
      logic [1:0]  e_inf;
      logic        e_ir;
   } vec_t;

   vec_t vecs [$];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   fires;
      int   n;

      // Single issue x=5 at cycle 0: result only on cycle 4, inflight 1,1,1,0.
      vecs.push_back('{1'b1, 32'd5, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1});
      vecs.push_back('{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd1, 1'b1});
      vecs.push_back('{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd1, 1'b1});
      vecs.push_back('{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd1, 1'b1});
      vecs.push_back('{1'b0, 32'd0, 1'b1, 1'b1, 32'd7, 2'd0, 1'b1});
      vecs.push_back('{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1});
      // Stream 10..19 on cycles 0..9, results 12..21 on cycles 4..13.
      for (int i = 0; i < 15; i++) begin
         n = 0;
         for (int j = i - 3; j < i; j++) if (j >= 0 && j <= 9) n++;
         v.iv    = (i <= 9);
         v.xv    = (i <= 9) ? 32'(10 + i) : 32'd0;
         v.ordy  = 1'b1;
         v.e_ov  = (i >= 4 && i <= 13);
         v.e_od  = (i >= 4 && i <= 13) ? 32'(8 + i) : 32'd0;
         v.e_inf = 2'(n);
         v.e_ir  = 1'b1;
         vecs.push_back(v);
      end

      rst = 1'b1; issue_valid = 0; out_ready = 0; x = 0;
      b_issue_valid = 0; b_out_ready = 1; b_x = 0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_inflight", inflight, 0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_issue_ready", issue_ready, 1);
      tick();

      // Table-driven single + stream
      foreach (vecs[k]) begin
         issue_valid = vecs[k].iv;
         x           = vecs[k].xv;
         out_ready   = vecs[k].ordy;
         #1;
         check($sformatf("vec%0d_out_valid", k), out_valid, vecs[k].e_ov);
         check($sformatf("vec%0d_out_data", k), out_data, vecs[k].e_od);
         check($sformatf("vec%0d_inflight", k), inflight, vecs[k].e_inf);
         check($sformatf("vec%0d_issue_ready", k), issue_ready, vecs[k].e_ir);
         tick();
      end
      issue_valid = 0;

      // Backpressure: exactly DEPTH issues accepted, head holds, credit after pop.
      out_ready = 0; issue_valid = 1; fires = 0;
      for (int c = 0; c < 12; c++) begin
         x = 32'(100 + fires);
         #1;
         if (c == 5) check("bp_ready_drop", issue_ready, 0);
         if (issue_valid && issue_ready) fires++;
         tick();
      end
      issue_valid = 0;
      check("bp_accepted", fires, 5);
      check("bp_full_valid", out_valid, 1);
      check("bp_head", out_data, 102);
      check("bp_ready_full", issue_ready, 0);
      tick();
      check("bp_head_stable", out_data, 102);
      out_ready = 1;
      #1;
      check("bp_ready_same_cycle", issue_ready, 0);
      tick();
      check("bp_ready_after_pop", issue_ready, 1);
      for (int c = 0; c < 20 && out_valid; c++) tick();
      check("bp_drained", out_valid, 0);
      check("bp_pops", pops_a, 16);
      issue_valid = 1; x = 32'd300;
      #1;
      check("bp_resume", issue_ready, 1);
      tick();
      issue_valid = 0;
      for (int c = 0; c < 8; c++) tick();

      // Throttle on DEPTH=2: issue_ready high on 2 of every 5 cycles.
      b_issue_valid = 1; fires = 0;
      for (int c = 0; c < 30; c++) begin
         b_x = 32'(200 + fires);
         #1;
         check($sformatf("thr_ready_c%0d", c), b_issue_ready, ((c % 5) < 2));
         if (b_inflight > 2'd2) check("thr_inflight", b_inflight, 2);
         if (b_issue_valid && b_issue_ready) fires++;
         tick();
      end
      b_issue_valid = 0;
      for (int c = 0; c < 10; c++) tick();
      check("thr_fires", fires, 12);
      check("thr_pops", pops_b, 12);
      check("thr_queue_empty", q_b.size(), 0);

      // Reset mid-flight: 2 buffered + 2 in flight, then discarded.
      out_ready = 0;
      for (int c = 0; c < 4; c++) begin
         issue_valid = 1; x = 32'(50 + c);
         tick();
      end
      issue_valid = 0;
      tick();
      check("mf_inflight", inflight, 2);
      check("mf_out_valid", out_valid, 1);
      check("mf_head", out_data, 52);
      rst = 1'b1;
      #1;
      check("mf_rst_out_valid", out_valid, 0);
      check("mf_rst_out_data", out_data, 0);
      check("mf_rst_inflight", inflight, 0);
      q_a.delete();
      tick(); tick();
      rst = 1'b0;
      #1;
      check("mf_issue_ready", issue_ready, 1);
      out_ready = 1;
      for (int c = 0; c < 6; c++) begin
         check($sformatf("mf_quiet_c%0d", c), out_valid, 0);
         tick();
      end
      issue_valid = 1; x = 32'd1;
      tick();
      issue_valid = 0;
      tick(); tick();
      check("mf_t3_valid", out_valid, 0);
      tick();
      check("mf_t4_valid", out_valid, 1);
      check("mf_t4_data", out_data, 3);
      tick();
      check("mf_t5_valid", out_valid, 0);
      check("final_queue_a", q_a.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
